// File: rtl/figan_pkg.sv
// Shared definitions for the pad frame controller: FSM state encoding and
// beat-count helpers derived from frame geometry.
package figan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Samples entering the pad stage per frame.
  function automatic int calc_in_beats(input int img_width, input int img_height);
    return img_width * img_height;
  endfunction

  // Samples leaving the pad stage per frame, padding included.
  function automatic int calc_out_beats(input int img_width, input int img_height,
                                        input int pad_top, input int pad_bottom,
                                        input int pad_left, input int pad_right);
    return (pad_left + img_width + pad_right) * (pad_top + img_height + pad_bottom);
  endfunction

endpackage

// File: rtl/pad_frame_ctrl_beat_counter.sv
// Saturating handshake-beat counter with flags for "current beat is the last"
// and "all beats seen"; it never wraps past TERMINAL.
module beat_counter #(
  parameter int WIDTH    = 9,
  parameter int TERMINAL = 289
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last,
  output logic full
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !full) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == WIDTH'(TERMINAL - 1));
  assign full = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/pad_frame_ctrl.sv
// Frame sequencer around an external padding stage: clears it, streams one
// frame in and the padded frame out, repeats for NUM_FRAMES frames.
// Optional stall watchdog: define PAD_FRAME_TIMEOUT_EN.
module pad_frame_ctrl
  import figan_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 14,
  parameter int IMG_HEIGHT = 14,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 2,
  parameter int PAD_LEFT   = 1,
  parameter int PAD_RIGHT  = 2,
  parameter int NUM_FRAMES = 4,
  parameter int CLR_CYCLES = 2
`ifdef PAD_FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic [7:0]            frame_idx,
  output logic                  frame_done,
  output logic                  run_done,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  pad_valid_in,
  output logic [DATA_WIDTH-1:0] pad_data_in,
  input  logic                  pad_ready_in,
  input  logic                  pad_valid_out,
  input  logic [DATA_WIDTH-1:0] pad_data_out,
  output logic                  pad_ready_out,
  output logic                  snk_valid,
  output logic [DATA_WIDTH-1:0] snk_data,
  input  logic                  snk_ready,
  output logic                  pad_clr_n
`ifdef PAD_FRAME_TIMEOUT_EN
  , output logic                timeout
`endif
);

  localparam int IN_BEATS  = calc_in_beats(IMG_WIDTH, IMG_HEIGHT);
  localparam int OUT_BEATS = calc_out_beats(IMG_WIDTH, IMG_HEIGHT, PAD_TOP, PAD_BOTTOM,
                                            PAD_LEFT, PAD_RIGHT);
  localparam int CNT_W     = $clog2(OUT_BEATS + 1);
  localparam int CLR_W     = $clog2(CLR_CYCLES + 1);

  state_t state, next_state;
  logic [CLR_W-1:0] clr_cnt;
  logic active, in_beat, out_beat, in_last, out_last;
  logic in_at_last, in_full, out_at_last, out_full;
  logic clr_done, last_frame;

  assign active     = (state == STREAM) || (state == DRAIN);
  assign in_beat    = src_valid && src_ready;
  assign out_beat   = snk_valid && snk_ready;
  assign in_last    = in_beat && in_at_last;
  assign out_last   = out_beat && out_at_last;
  assign clr_done   = (clr_cnt == CLR_W'(CLR_CYCLES - 1));
  assign last_frame = (frame_idx == 8'(NUM_FRAMES - 1));
  assign busy       = (state != IDLE);

  beat_counter #(.WIDTH(CNT_W), .TERMINAL(IN_BEATS)) u_in_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!active),
    .enable (in_beat),
    .last   (in_at_last),
    .full   (in_full)
  );

  beat_counter #(.WIDTH(CNT_W), .TERMINAL(OUT_BEATS)) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!active),
    .enable (out_beat),
    .last   (out_at_last),
    .full   (out_full)
  );

`ifdef PAD_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_cnt;
  logic          timeout_hit;

  assign timeout_hit = active && !out_beat && (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      stall_cnt <= (active && !out_beat) ? stall_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        timeout <= 1'b0;
      end else if (timeout_hit) begin
        timeout <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start) next_state = CLEAR;
      CLEAR:  if (clr_done) next_state = STREAM;
      STREAM, DRAIN: begin
        if (out_last) begin
          next_state = last_frame ? DONE : CLEAR;
        end else if (state == STREAM && in_last) begin
          next_state = DRAIN;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
`ifdef PAD_FRAME_TIMEOUT_EN
    if (timeout_hit) next_state = IDLE;
`endif
  end

  always_comb begin
    src_ready     = 1'b0;
    pad_valid_in  = 1'b0;
    pad_data_in   = '0;
    snk_valid     = 1'b0;
    snk_data      = '0;
    pad_ready_out = 1'b0;
    if (state == STREAM) begin
      src_ready    = pad_ready_in && !in_full;
      pad_valid_in = src_valid && !in_full;
      pad_data_in  = src_data;
    end
    // Gating on out_full keeps any surplus pad output away from the sink.
    if (active) begin
      snk_valid     = pad_valid_out && !out_full;
      snk_data      = pad_data_out;
      pad_ready_out = snk_ready && !out_full;
    end
  end

  // pad_clr_n follows next_state so it is low for exactly the CLEAR cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_idx  <= '0;
      frame_done <= 1'b0;
      run_done   <= 1'b0;
      pad_clr_n  <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      frame_done <= out_last;
      run_done   <= (state == DONE);
      pad_clr_n  <= (next_state != CLEAR);
      clr_cnt    <= (state == CLEAR && !clr_done) ? clr_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        frame_idx <= '0;
      end else if (out_last && !last_frame) begin
        frame_idx <= frame_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pad_frame_ctrl.sv
// Self-checking bench for pad_frame_ctrl: behavioural pad stage, scoreboard of
// padded output order, reset/start/done sequencing checks.
`timescale 1ns/1ps
module tb_pad_frame_ctrl;

  localparam int DW = 16, W = 14, H = 14, PT = 1, PB = 2, PL = 1, PR = 2;
  localparam int NF = 4, CLR = 2, TMO = 64;
  localparam int OW = PL + W + PR, OH = PT + H + PB;
  localparam int IN_N = W * H, OUT_N = OW * OH;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, frame_done, run_done, pad_clr_n;
  logic [7:0] frame_idx;
  logic src_valid = 1'b0, src_ready;
  logic [DW-1:0] src_data;
  logic pad_valid_in, pad_ready_in = 1'b1;
  logic [DW-1:0] pad_data_in;
  logic pad_valid_out, pad_ready_out;
  logic [DW-1:0] pad_data_out;
  logic snk_valid, snk_ready = 1'b0;
  logic [DW-1:0] snk_data;
`ifdef PAD_FRAME_TIMEOUT_EN
  logic timeout;
`endif

  always #5 clk = ~clk;

  pad_frame_ctrl #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PAD_TOP(PT), .PAD_BOTTOM(PB),
    .PAD_LEFT(PL), .PAD_RIGHT(PR), .NUM_FRAMES(NF), .CLR_CYCLES(CLR)
`ifdef PAD_FRAME_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_idx(frame_idx),
    .frame_done(frame_done), .run_done(run_done),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pad_valid_in(pad_valid_in), .pad_data_in(pad_data_in), .pad_ready_in(pad_ready_in),
    .pad_valid_out(pad_valid_out), .pad_data_out(pad_data_out), .pad_ready_out(pad_ready_out),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .pad_clr_n(pad_clr_n)
`ifdef PAD_FRAME_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int tag, input int f, input int i);
    logic [3:0] t;
    t = 4'(tag + f);
    return {t, 12'(i)};
  endfunction

  function automatic logic is_pad(input int p);
    int r, c;
    r = p / OW;
    c = p % OW;
    return (p >= OUT_N) || (r < PT) || (r >= PT + H) || (c < PL) || (c >= PL + W);
  endfunction

  // Behavioural pad stage: raster walk over the padded frame, zeros on the
  // border, 16'hBEEF beyond the last position to expose overrun.
  logic [DW-1:0] pad_mem [0:255];
  int wr_ptr = 0, rd_ptr = 0, pos = 0;
  logic cur_pad, over;
  assign cur_pad       = is_pad(pos);
  assign over          = (pos >= OUT_N);
  assign pad_valid_out = cur_pad || (wr_ptr != rd_ptr);
  assign pad_data_out  = over ? 16'hBEEF : (cur_pad ? '0 : pad_mem[rd_ptr[7:0]]);

  always @(posedge clk) begin
    if (!pad_clr_n) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
      pos    <= 0;
    end else begin
      if (pad_valid_in && pad_ready_in) begin
        pad_mem[wr_ptr[7:0]] <= pad_data_in;
        wr_ptr <= wr_ptr + 1;
      end
      if (pad_valid_out && pad_ready_out) begin
        pos <= pos + 1;
        if (!cur_pad) rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Source: data is a function of run tag, frame-in-run and sample index.
  int tag_base = 1, in_cnt = 0, frames_in_run = 0;
  assign src_data = data_of(tag_base, frames_in_run, in_cnt);

  always @(posedge clk) begin
    if (!busy) begin
      in_cnt        <= 0;
      frames_in_run <= 0;
    end else if (frame_done) begin
      in_cnt        <= 0;
      frames_in_run <= frames_in_run + 1;
    end else if (src_valid && src_ready) begin
      in_cnt <= in_cnt + 1;
    end
  end

  // Sink ready: held value or 50% random.
  logic hold_ready = 1'b1, rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    snk_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
  end

  logic [DW-1:0] exp_q[$];

  task automatic push_run(input int tag);
    int k;
    for (int f = 0; f < NF; f++) begin
      k = 0;
      for (int p = 0; p < OUT_N; p++) begin
        if (is_pad(p)) begin
          exp_q.push_back('0);
        end else begin
          exp_q.push_back(data_of(tag, f, k));
          k++;
        end
      end
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int snk_cnt = 0, fd_total = 0, rd_total = 0, clr_low = 0;
  logic fd_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      snk_cnt = 0;
      clr_low = 0;
      fd_prev = 1'b0;
    end else begin
      if (snk_valid && snk_ready) begin
        if (snk_cnt == 0) check("frame_idx", frame_idx, frames_in_run);
        check("snk_within_frame", snk_cnt < OUT_N, 1);
        check("scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("snk_data", snk_data, exp_q.pop_front());
        snk_cnt++;
      end
      if (frame_done) begin
        fd_total++;
        check("snk_beats", snk_cnt, OUT_N);
        check("in_beats", in_cnt, IN_N);
        snk_cnt = 0;
      end
      if (run_done) begin
        rd_total++;
        check("run_done_after_frame_done", fd_prev, 1);
        check("frames_per_run", frames_in_run, NF);
      end
      if (!pad_clr_n && busy) begin
        clr_low++;
      end else if (clr_low != 0) begin
        check("clr_pulse_len", clr_low, CLR);
        clr_low = 0;
      end
      fd_prev = frame_done;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("run_completes", busy, 0);
    @(negedge clk);
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_run_done"}, run_done, 0);
    check({tag, "_pad_clr_n"}, pad_clr_n, 0);
    check({tag, "_frame_idx"}, frame_idx, 0);
    check({tag, "_src_ready"}, src_ready, 0);
    check({tag, "_pad_valid_in"}, pad_valid_in, 0);
    check({tag, "_pad_data_in"}, pad_data_in, 0);
    check({tag, "_snk_valid"}, snk_valid, 0);
    check({tag, "_snk_data"}, snk_data, 0);
    check({tag, "_pad_ready_out"}, pad_ready_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fd0, rd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    src_valid = 1'b1;
    check_all_quiet("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("clr_n_after_reset", pad_clr_n, 1);
    check("idle_busy", busy, 0);

    // Four clean frames, sink always ready.
    tag_base = 1;
    push_run(1);
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_idle(4000);
    check("run_a_run_done", rd_total, 1);
    check("run_a_frame_done", fd_total, NF);
    check("run_a_queue_empty", exp_q.size(), 0);

    // Random sink backpressure, plus a start while streaming.
    tag_base = 5;
    push_run(5);
    rand_ready = 1'b1;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (snk_cnt < 20 && n < 2000);
    check("reach_mid_stream", snk_cnt >= 20, 1);
    pulse_start();
    @(negedge clk);
    check("start_ignored_idx", frame_idx, 0);
    check("start_ignored_busy", busy, 1);
    wait_idle(8000);
    rand_ready = 1'b0;
    check("run_b_run_done", rd_total, 2);
    check("run_b_frame_done", fd_total, 2 * NF);
    check("run_b_queue_empty", exp_q.size(), 0);

    // Reset mid-frame around output beat 100.
    tag_base = 9;
    hold_ready = 1'b1;
    push_run(9);
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (snk_cnt < 100 && n < 2000);
    check("reach_beat_100", snk_cnt, 100);
    exp_q.delete();
    fd0 = fd_total;
    rd0 = rd_total;
    rst_n = 1'b0;
    #1;
    check_all_quiet("midreset");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset_no_frame_done", fd_total, fd0);
    check("midreset_no_run_done", rd_total, rd0);
    check("midreset_idle", busy, 0);

    // Clean run after the reset.
    tag_base = 3;
    push_run(3);
    pulse_start();
    wait_idle(4000);
    check("run_d_run_done", rd_total, rd0 + 1);
    check("run_d_frame_done", fd_total, fd0 + NF);
    check("run_d_queue_empty", exp_q.size(), 0);

`ifdef PAD_FRAME_TIMEOUT_EN
    // Sink stalled: abort after TMO cycles without an output beat.
    tag_base = 7;
    hold_ready = 1'b0;
    rd0 = rd_total;
    fd0 = fd_total;
    repeat (2) @(posedge clk);
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      if (busy) n++;
    end while (busy && n < 500);
    check("timeout_flag", timeout, 1);
    check("timeout_busy_cycles", n, CLR + TMO);
    check("timeout_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("timeout_sticky", timeout, 1);
    check("timeout_no_run_done", rd_total, rd0);
    check("timeout_no_frame_done", fd_total, fd0);
    tag_base = 11;
    hold_ready = 1'b1;
    push_run(11);
    repeat (2) @(posedge clk);
    pulse_start();
    check("timeout_cleared_by_start", timeout, 0);
    wait_idle(4000);
    check("run_e_run_done", rd_total, rd0 + 1);
    check("run_e_queue_empty", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pad_frame_ctrl.md
PAD_FRAME_CTRL -- requirements
Module: pad_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameters IMG_WIDTH/IMG_HEIGHT, default 14/14, unpadded frame size.
REQ-003 SHALL have parameters PAD_TOP/PAD_BOTTOM/PAD_LEFT/PAD_RIGHT, default 1/2/1/2, padding of the controlled pad stage.
REQ-004 SHALL have parameter NUM_FRAMES, default 4, frames per run (1..255).
REQ-005 SHALL have parameter CLR_CYCLES, default 2, pad clear pulse length (>=1).
REQ-006 Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  run request.
- busy  out  1  run in progress.
- frame_idx  out  8  current frame.
- frame_done  out  1  one-cycle pulse per completed frame.
- run_done  out  1  one-cycle pulse at end of run.
- src_valid, src_data[DATA_WIDTH], src_ready  in, in, out  producer stream.
- pad_valid_in, pad_data_in, pad_ready_in  out, out, in  pad input side.
- pad_valid_out, pad_data_out, pad_ready_out  in, in, out  pad output side.
- snk_valid, snk_data, snk_ready  out, out, in  consumer stream.
- pad_clr_n  out  1  active-low clear to pad stage.

Function
REQ-007 SHALL define IN_BEATS=IMG_WIDTH*IMG_HEIGHT and OUT_BEATS=(PAD_LEFT+IMG_WIDTH+PAD_RIGHT)*(PAD_TOP+IMG_HEIGHT+PAD_BOTTOM); default 196/289.
REQ-008 FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-009 IDLE: start=1 -> CLEAR, frame_idx<=0; start ignored in all other states.
REQ-010 CLEAR: pad_clr_n=0 for exactly CLR_CYCLES cycles, in/out counters zeroed, then STREAM.
REQ-011 STREAM: pad_valid_in=src_valid, pad_data_in=src_data, src_ready=pad_ready_in, combinational, zero latency.
REQ-012 In beat = src_valid&&src_ready; at the IN_BEATS-th in beat -> DRAIN; in DRAIN src_ready=0, pad_valid_in=0.
REQ-013 STREAM/DRAIN: snk_valid=pad_valid_out, snk_data=pad_data_out, pad_ready_out=snk_ready; out beat = snk_valid&&snk_ready.
REQ-014 At the OUT_BEATS-th out beat (may coincide with last in beat): frame_done pulse next cycle; if frame_idx==NUM_FRAMES-1 -> DONE else frame_idx+1 and -> CLEAR; out beats past OUT_BEATS SHALL never reach sink.
REQ-015 DONE: run_done pulse one cycle, -> IDLE.
REQ-016 Outside STREAM/DRAIN: src_ready=0, pad_valid_in=0, snk_valid=0, pad_ready_out=0, data outputs 0.
REQ-017 busy=1 in every state except IDLE.
REQ-018 Counters SHALL be sized $clog2(OUT_BEATS+1) and never wrap.

Reset
REQ-019 rst_n low, any time: state IDLE, counters 0, frame_idx 0, busy/frame_done/run_done 0, pad_clr_n 0; all handshake valids/readies 0.
REQ-020 pad_clr_n SHALL return to 1 on the first clock after rst_n deasserts; a mid-frame reset discards the frame with no done pulses.

Configuration
REQ-021 Macro PAD_FRAME_TIMEOUT_EN: when defined, parameter TIMEOUT_CYCLES (default 4096) and output timeout (1 bit) exist; STREAM/DRAIN with no out beat for TIMEOUT_CYCLES consecutive cycles -> timeout set sticky, run aborted to IDLE without run_done; timeout cleared by next start or reset.
REQ-022 Without the macro: no timeout port or counter; stalls wait indefinitely.

Structure
REQ-023 State encoding typedef and IN_BEATS/OUT_BEATS helper constants SHALL live in shared package figan_pkg.
REQ-024 One sub-module beat_counter (enable, clear, terminal-count flag) SHALL be instantiated twice for in and out beats.

Verification
REQ-025 Reset then start, NUM_FRAMES=1, src always valid, snk always ready -> 196 in beats, 289 out beats, frame_done once, run_done next cycle, busy low after.
REQ-026 NUM_FRAMES=4 -> frame_idx 0..3, 4 frame_done, 1 run_done, pad_clr_n low 2 cycles between frames.
REQ-027 Random snk_ready 50% -> exactly 289 snk beats per frame, data matches pad output order, no beat after 289th.
REQ-028 start asserted during STREAM -> ignored, frame_idx unchanged.
REQ-029 rst_n low at out beat 100 -> all outputs zero same cycle, no done pulses, next start runs clean frame.
REQ-030 With PAD_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=64, snk_ready held 0 -> timeout=1 after 64 cycles, state IDLE, no run_done.
